uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 SHALL have port data  output  8  received byte; stable while valid=1.
REQ-007 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-008 SHALL have port ready  input  1  consumer accepts data on a cycle where valid=1 and ready=1.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress, i.e. state != IDLE.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-012 SHALL compute CLKS_PER_BIT = CLK_FREQ/BAUD by truncating integer division; ratios below 4 are unsupported.
REQ-013 SHALL pass rx through a two-flop synchronizer; all frame logic uses the synchronized value rxs.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 In IDLE, on rxs=0, SHALL clear the bit-period counter and go to START.
REQ-016 In START, at counter = CLKS_PER_BIT/2 - 1 (mid start bit), SHALL resample rxs.
- rxs=1: treat as a glitch, return to IDLE, no output.
- rxs=0: clear the counter and go to DATA.
REQ-017 In DATA, SHALL sample rxs each time the counter reaches CLKS_PER_BIT-1 (mid-bit), then clear the counter.
- Samples shift into the shift register LSB first.
- After the 8th sample, go to STOP.
REQ-018 In STOP, at counter = CLKS_PER_BIT-1, SHALL sample rxs.
- rxs=1: deliver the byte per REQ-019/020 and go to IDLE.
- rxs=0: pulse frame_err, discard the byte, go to BREAK.
REQ-019 On delivery with valid=0, or with valid=1 and ready=1 in the same cycle: SHALL load data and set valid=1 on that edge; no overrun.
REQ-020 On delivery with valid=1 and ready=0: SHALL retain the held data, keep valid=1, drop the new byte and pulse overrun.
REQ-021 Whenever valid=1 and ready=1 with no simultaneous delivery, SHALL clear valid on that edge; data keeps its value.
REQ-022 In BREAK, SHALL remain until rxs=1, then go to IDLE; no frame starts while the line stays low.
REQ-023 A new start bit SHALL be detectable on the first IDLE cycle after STOP, allowing back-to-back frames with zero idle gap.
REQ-024 Latency: valid SHALL rise at most 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the falling edge on rx.
REQ-025 frame_err and overrun SHALL each be high for exactly one cycle per event and SHALL never assert simultaneously.
REQ-026 ready SHALL have no effect while valid=0.

Reset
REQ-027 While rst_n=0, SHALL hold:
- data=0x00, valid=0, busy=0, frame_err=0, overrun=0
- both synchronizer flops=1
- state=IDLE; counter, bit index and shift register cleared
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the partial byte is never delivered.
REQ-029 After reset release, SHALL not start a frame until rxs has been sampled high then low.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, CLKS_PER_BIT=10)
REQ-030 Single frame: frame 0x41 with ready=1 -> valid pulses 1 cycle with data=0x41; frame_err=0; overrun=0; busy low afterwards.
REQ-031 Glitch: rx low for 3 cycles, then high -> no valid, no frame_err; busy returns to 0 within 10 cycles.
REQ-032 Framing error then recovery:
- Stimulus: frame 0x55 with stop bit 0, rx held low 30 more cycles, then high, then frame 0x0A.
- Response: one frame_err pulse, valid stays 0 through the break, then data=0x0A with valid=1.
REQ-033 Overrun:
- Stimulus: ready=0; frames 0x31 then 0x32; then ready=1 for 1 cycle.
- Response: valid=1 with data=0x31 throughout; one overrun pulse at the second stop sample; valid=0 after the handshake, data still 0x31.
REQ-034 Reset mid-frame: rst_n pulsed low after 4 data bits of 0x99 -> all outputs at reset values; next frame 0x7E received correctly with no frame_err.
REQ-035 Back-to-back: frames 0x00 then 0xFF with zero idle gap, ready=1 -> two valid pulses, data 0x00 then 0xFF; no errors.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line, byte hand-off and status signals of uart_rx.
//                master = line driver / byte consumer, slave = receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx, ready,
    input  data, valid, busy, frame_err, overrun
  );

  modport slave (
    input  rx, ready,
    output data, valid, busy, frame_err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, mid-bit sampling, valid/ready byte output
//                with overrun and framing-error pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  // Counter values that mark mid start bit and one full bit period.
  localparam logic [CW-1:0] C_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          meta_q, rxs_q;
  logic [7:0]    data_q;
  logic          valid_q, frame_err_q, overrun_q;
  logic          deliver, ferr_d;

  // Two-flop synchronizer; resets high so a line held low at reset release
  // is seen as a high-to-low transition rather than an instant start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= bus.rx;
      rxs_q  <= meta_q;
    end
  end

  // Frame state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: sample mid start bit, then every full bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == C_HALF_END) begin
          cnt_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == C_BIT_END) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == C_BIT_END) begin
          cnt_d = '0;
          if (rxs_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output holding register: a byte waiting unconsumed is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_d;
      overrun_q   <= deliver & valid_q & ~bus.ready;
      if (deliver && (!valid_q || bus.ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready && !deliver) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx at 10 clocks per bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 10;
  localparam int LAT_MAX = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk;
  logic rst_n;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Monitor state, updated shortly after each rising edge.
  logic [7:0] caps[$];
  int cyc      = 0;
  int last_rise = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;
  int vhigh    = 0;
  int vfalls   = 0;
  int busy_seen = 0;
  logic vprev  = 1'b0;

  // Record valid rising edges, pulse widths and busy activity.
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (bus.valid && !vprev) begin
      caps.push_back(bus.data);
      last_rise = cyc;
    end
    if (!bus.valid && vprev) vfalls = vfalls + 1;
    if (bus.valid) vhigh = vhigh + 1;
    if (bus.frame_err) ferr_cnt = ferr_cnt + 1;
    if (bus.overrun) ovr_cnt = ovr_cnt + 1;
    if (bus.frame_err && bus.overrun) both_cnt = both_cnt + 1;
    if (bus.busy) busy_seen = 1;
    vprev = bus.valid;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp = n_cmp + 1;
    if (act < lo || act > hi) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    caps.delete();
    ferr_cnt  = 0;
    ovr_cnt   = 0;
    vhigh     = 0;
    vfalls    = 0;
    busy_seen = 0;
  endtask

  task automatic put_bit(input logic b);
    bus.rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(stop);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_caps;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];
  int   fall_cyc;

  initial begin
    vecs[0] = '{8'h41, 1'b1, 8'h41, 1, 0};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[2] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[3] = '{8'hC3, 1'b0, 8'h00, 0, 1};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1, 0};

    // Reset state
    rst_n     = 1'b0;
    bus.rx    = 1'b1;
    bus.ready = 1'b0;
    tick(3);
    check("rst_data", int'(bus.data), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ferr", int'(bus.frame_err), 0);
    check("rst_ovr", int'(bus.overrun), 0);
    rst_n = 1'b1;
    tick(5);

    // Table-driven single frames with ready held high
    bus.ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      clr();
      fall_cyc = cyc;
      send_frame(vecs[v].din, vecs[v].stop);
      bus.rx = 1'b1;
      tick(20);
      check($sformatf("v%0d_caps", v), caps.size(), vecs[v].exp_caps);
      if (caps.size() > 0)
        check($sformatf("v%0d_data", v), int'(caps[0]), int'(vecs[v].exp_data));
      check($sformatf("v%0d_vhigh", v), vhigh, vecs[v].exp_caps);
      check($sformatf("v%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
      check($sformatf("v%0d_ovr", v), ovr_cnt, 0);
      check($sformatf("v%0d_busy", v), int'(bus.busy), 0);
      if (v == 0) check_range("latency", last_rise - fall_cyc, 9 * CPB, LAT_MAX);
    end

    // Glitch: three low cycles must not start a frame
    clr();
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(10);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy", int'(bus.busy), 0);
    check("glitch_caps", caps.size(), 0);
    check("glitch_ferr", ferr_cnt, 0);

    // Framing error, long break, then recovery
    clr();
    send_frame(8'h55, 1'b0);
    tick(30);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_busy", int'(bus.busy), 1);
    check("brk_caps", caps.size(), 0);
    bus.rx = 1'b1;
    tick(5);
    send_frame(8'h0A, 1'b1);
    tick(20);
    check("brk_rec_caps", caps.size(), 1);
    if (caps.size() > 0) check("brk_rec_data", int'(caps[0]), 8'h0A);
    check("brk_rec_ferr", ferr_cnt, 1);

    // Overrun: second byte dropped while first is held
    clr();
    bus.ready = 1'b0;
    send_frame(8'h31, 1'b1);
    tick(5);
    send_frame(8'h32, 1'b1);
    tick(20);
    check("ovr_valid", int'(bus.valid), 1);
    check("ovr_data", int'(bus.data), 8'h31);
    check("ovr_cnt", ovr_cnt, 1);
    check("ovr_vfalls", vfalls, 0);
    check("ovr_ferr", ferr_cnt, 0);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    tick(1);
    check("ovr_hs_valid", int'(bus.valid), 0);
    check("ovr_hs_data", int'(bus.data), 8'h31);

    // Reset mid-frame after four data bits of 0x99
    clr();
    bus.ready = 1'b1;
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b0);
    put_bit(1'b1);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    tick(2);
    check("mid_rst_data", int'(bus.data), 0);
    check("mid_rst_valid", int'(bus.valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    tick(5);
    check("mid_rst_caps", caps.size(), 0);
    clr();
    send_frame(8'h7E, 1'b1);
    tick(20);
    check("post_rst_caps", caps.size(), 1);
    if (caps.size() > 0) check("post_rst_data", int'(caps[0]), 8'h7E);
    check("post_rst_ferr", ferr_cnt, 0);

    // Back-to-back frames with zero idle gap
    clr();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    check("b2b_caps", caps.size(), 2);
    if (caps.size() == 2) begin
      check("b2b_data0", int'(caps[0]), 8'h00);
      check("b2b_data1", int'(caps[1]), 8'hFF);
    end
    check("b2b_ferr", ferr_cnt, 0);
    check("b2b_ovr", ovr_cnt, 0);

    check("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
